// File: rtl/acumulator_produse_4biti_pkg.sv
// Shared definitions for the product accumulator: FSM states, default sizes,
// multiplier product width and the counter width helper.
package acumulator_produse_4biti_pkg;

  localparam int N_TERMS_DEF = 4;
  localparam int ACC_W_DEF   = 10;
  localparam int PROD_W      = 8;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Term counter width; a single-term build still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acumulator_produse_4biti_if.sv
// Operand-in / sum-out handshake bundle of the product accumulator.
// master = upstream + downstream side, slave = accumulator side.
interface acumulator_produse_4biti_if
  import acumulator_produse_4biti_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/acumulator_produse_4biti_mul.sv
// 4x4 unsigned combinational multiplier feeding the accumulator.
module multiplicator_4biti
  import acumulator_produse_4biti_pkg::*;
(
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic [PROD_W-1:0] prod
);
  assign prod = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/acumulator_produse_4biti.sv
// Multiply-accumulate stage: sums N_TERMS products a*b, then holds the result
// until downstream takes it. Overflow is sticky per result.
// Build option: SATURATE_EN clamps the accumulator at all-ones on overflow;
// without it the accumulator wraps modulo 2^ACC_W.
module acumulator_produse_4biti
  import acumulator_produse_4biti_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  acumulator_produse_4biti_if.slave   bus
);
  localparam int                  CNT_W = cnt_w(N_TERMS);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(N_TERMS - 1);

  state_t            r_state, w_state_nx;
  logic [ACC_W-1:0]  r_acc,   w_acc_nx;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nx;
  logic              r_ovf,   w_ovf_nx;

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_add;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_add;

  multiplicator_4biti u_mul (
    .a    (bus.a),
    .b    (bus.b),
    .prod (w_prod)
  );

  // One extra bit on the adder exposes the carry used for overflow.
  assign w_add   = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
  assign w_carry = w_add[ACC_W];

`ifdef SATURATE_EN
  // Once clamped, any further nonzero product carries again, so it stays clamped.
  assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
  assign w_acc_add = w_add[ACC_W-1:0];
`endif

  // State, accumulator, term counter and overflow flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_cnt   <= w_cnt_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  // Next-state logic; clr overrides every handshake in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_ovf_nx   = r_ovf;
    if (clr) begin
      w_state_nx = ST_ACC;
      w_acc_nx   = '0;
      w_cnt_nx   = '0;
      w_ovf_nx   = 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (bus.in_valid) begin
            w_acc_nx = w_acc_add;
            w_ovf_nx = r_ovf | w_carry;
            if (r_cnt == LAST) begin
              w_cnt_nx   = '0;
              w_state_nx = ST_DONE;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            w_acc_nx   = '0;
            w_ovf_nx   = 1'b0;
            w_state_nx = ST_ACC;
          end
        end
        default: w_state_nx = ST_ACC;
      endcase
    end
  end

  // All outputs come straight from registers, so the held sum is stable.
  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.sum       = r_acc;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_acumulator_produse_4biti.sv
// Bench for acumulator_produse_4biti: DUT A uses defaults (4 terms, 10 bits),
// DUT B uses 2 terms, 8 bits. Expected sums come from the exact integer total
// of accepted products, reduced by wrap or clamp (SATURATE_EN).
module tb_acumulator_produse_4biti;
  import acumulator_produse_4biti_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic clrA = 1'b0;
  logic clrB = 1'b0;

  always #5 clk = ~clk;

  acumulator_produse_4biti_if #(.ACC_W(10)) ifa ();
  acumulator_produse_4biti_if #(.ACC_W(8))  ifb ();

  acumulator_produse_4biti #(.N_TERMS(4), .ACC_W(10)) dut_a (
    .clk (clk), .rst (rst), .clr (clrA), .bus (ifa)
  );
  acumulator_produse_4biti #(.N_TERMS(2), .ACC_W(8)) dut_b (
    .clk (clk), .rst (rst), .clr (clrB), .bus (ifb)
  );

  int total = 0;
  int bad   = 0;

  // Model: per DUT, whether a result is being held, terms taken, exact total.
  bit m_hold [2];
  int m_cnt  [2];
  int m_tot  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = 0; m_cnt[i] = 0; m_tot[i] = 0;
    end
  end

  function automatic int exp_sum(input int tot, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef SATURATE_EN
    return (tot > mx) ? mx : tot;
`else
    return tot % (1 << w);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Check DUT against the model, then advance the model to the next edge.
  task automatic model_step(input int i, input int n, input int w, input string nm,
                            input logic rst_i, input logic clr_i, input logic iv,
                            input logic [3:0] a_i, input logic [3:0] b_i,
                            input logic ordy, input logic irdy_d, input logic ovld_d,
                            input logic [15:0] sum_d, input logic ovf_d);
    if (rst_i) begin
      m_hold[i] = 0; m_cnt[i] = 0; m_tot[i] = 0;
    end
    chk({nm, " in_ready"},  32'(irdy_d), 32'(!m_hold[i]));
    chk({nm, " out_valid"}, 32'(ovld_d), 32'(m_hold[i]));
    chk({nm, " sum"},       32'(sum_d),  32'(exp_sum(m_tot[i], w)));
    chk({nm, " ovf"},       32'(ovf_d),  32'(m_tot[i] > ((1 << w) - 1)));
    if (!rst_i) begin
      if (clr_i) begin
        m_hold[i] = 0; m_cnt[i] = 0; m_tot[i] = 0;
      end else if (m_hold[i]) begin
        if (ordy) begin
          m_hold[i] = 0; m_tot[i] = 0;
        end
      end else if (iv) begin
        m_tot[i] += int'(a_i) * int'(b_i);
        m_cnt[i]++;
        if (m_cnt[i] == n) begin
          m_cnt[i] = 0; m_hold[i] = 1;
        end
      end
    end
  endtask

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    model_step(0, 4, 10, "A", rst, clrA, ifa.in_valid, ifa.a, ifa.b, ifa.out_ready,
               ifa.in_ready, ifa.out_valid, 16'(ifa.sum), ifa.ovf);
    model_step(1, 2, 8, "B", rst, clrB, ifb.in_valid, ifb.a, ifb.b, ifb.out_ready,
               ifb.in_ready, ifb.out_valid, 16'(ifb.sum), ifb.ovf);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [3:0] av, input logic [3:0] bv);
    ifa.a = av; ifa.b = bv; ifa.in_valid = 1'b1;
    tick();
  endtask

  task automatic beat_b(input logic [3:0] av, input logic [3:0] bv);
    ifb.a = av; ifb.b = bv; ifb.in_valid = 1'b1;
    tick();
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.a = '0; ifa.b = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.a = '0; ifb.b = '0; ifb.out_ready = 1'b1;

    // Reset state
    tick();
    chk("rst in_ready",  32'(ifa.in_ready), 32'd1);
    chk("rst out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst sum",       32'(ifa.sum), 32'd0);
    chk("rst ovf",       32'(ifa.ovf), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic sum: 6+20+21+0
    beat_a(3, 2); beat_a(5, 4); beat_a(7, 3); beat_a(0, 0);
    ifa.in_valid = 1'b0;
    chk("t2 out_valid", 32'(ifa.out_valid), 32'd1);
    chk("t2 sum",       32'(ifa.sum), 32'd47);
    chk("t2 ovf",       32'(ifa.ovf), 32'd0);
    tick();
    chk("t2 in_ready after take", 32'(ifa.in_ready), 32'd1);

    // Back-pressure: result held, beat during DONE is not consumed
    ifa.out_ready = 1'b0;
    beat_a(3, 2); beat_a(5, 4); beat_a(7, 3); beat_a(0, 0);
    ifa.a = 4'd1; ifa.b = 4'd1; ifa.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3 held sum",     32'(ifa.sum), 32'd47);
      chk("t3 held in_ready", 32'(ifa.in_ready), 32'd0);
      tick();
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    chk("t3 in_ready after take", 32'(ifa.in_ready), 32'd1);
    chk("t3 out_valid after take", 32'(ifa.out_valid), 32'd0);
    beat_a(2, 2); beat_a(2, 2); beat_a(2, 2); beat_a(2, 2);
    ifa.in_valid = 1'b0;
    chk("t3 next sum", 32'(ifa.sum), 32'd16);
    tick();

    // Overflow on the 8-bit, 2-term instance: 450 wraps to 194 or clamps to 255
    beat_b(15, 15); beat_b(15, 15);
    ifb.in_valid = 1'b0;
    chk("t4 out_valid", 32'(ifb.out_valid), 32'd1);
`ifdef SATURATE_EN
    chk("t4 sum", 32'(ifb.sum), 32'd255);
`else
    chk("t4 sum", 32'(ifb.sum), 32'd194);
`endif
    chk("t4 ovf", 32'(ifb.ovf), 32'd1);
    tick();
    chk("t4 ovf cleared", 32'(ifb.ovf), 32'd0);

    // clr beats a concurrent valid beat
    beat_a(15, 15); beat_a(15, 15);
    clrA = 1'b1; ifa.a = 4'd15; ifa.b = 4'd15; ifa.in_valid = 1'b1;
    tick();
    clrA = 1'b0; ifa.in_valid = 1'b0;
    chk("t5 sum after clr", 32'(ifa.sum), 32'd0);
    beat_a(1, 1); beat_a(1, 1); beat_a(1, 1); beat_a(1, 1);
    ifa.in_valid = 1'b0;
    chk("t5 out_valid", 32'(ifa.out_valid), 32'd1);
    chk("t5 sum", 32'(ifa.sum), 32'd4);
    tick();

    // Async reset between edges while holding a result
    ifa.out_ready = 1'b0;
    beat_a(1, 2); beat_a(1, 2); beat_a(1, 2); beat_a(1, 2);
    ifa.in_valid = 1'b0;
    chk("t6 sum before rst", 32'(ifa.sum), 32'd8);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 out_valid async", 32'(ifa.out_valid), 32'd0);
    chk("t6 sum async",       32'(ifa.sum), 32'd0);
    chk("t6 in_ready async",  32'(ifa.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
